ssd_scan_sched: RTL and testbench

- Refresh scheduler for the 4-digit seven-segment scan mux.
- Generates the 2-bit digit-select that drives the mux's `ssd_ctl_en`, with a programmable slot time and anti-ghosting dead time at the start of each slot.
- Double-buffers the four BCD/hex nibbles that feed the mux's `in0..in3`. New values are accepted through a req/ack handshake and committed only at a frame boundary, so a frame never mixes old and new digits.

---
 rtl/ssd_scan_sched.sv | 140 ++++++++++++++
 tb/tb_ssd_scan_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_sched.sv
// ssd_scan_sched: refresh scheduler for a 4-digit seven-segment scan mux.
// It generates the digit select, the dead-time blanking and the frame tick,
// and double-buffers the four display nibbles. A new value is taken through
// a req/ack handshake and committed only at a frame boundary.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   en           run enable (reaches the scan one cycle later)
//   load_req     level request to load data_in
//   data_in      new digits, [3:0]=digit0 .. [15:12]=digit3
//   load_ack     one-cycle pulse: data_in was captured
//   pend_full    pending buffer holds an uncommitted value
//   ssd_ctl_en   digit index to the scan mux
//   disp_data    active digits; nibble k drives the mux's in_k
//   scan_blank   1 = all digits must be driven off
//   frame_tick   one-cycle pulse at the start of each frame
//
// Optional feature (macro SSD_SCAN_BLINK_EN): adds the blink_mask input and
// the BLINK_FRAMES parameter. Masked digits are blanked for their whole slot
// during alternate blocks of BLINK_FRAMES frames.
module ssd_scan_sched #(
    parameter int SLOT_CYCLES  = 25000,
    parameter int DEAD_CYCLES  = 1000,
    parameter int CNT_W        = 16
`ifdef SSD_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load_req,
    input  logic [15:0] data_in,
`ifdef SSD_SCAN_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic        load_ack,
    output logic        pend_full,
    output logic [1:0]  ssd_ctl_en,
    output logic [15:0] disp_data,
    output logic        scan_blank,
    output logic        frame_tick
);

    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic             slot_end;
    logic             frame_end;
    logic             blank_nxt;
    logic [15:0]      active;
    logic [15:0]      pending;

`ifdef SSD_SCAN_BLINK_EN
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FCW-1:0] fcnt;
    logic           phase;
    logic           phase_nxt;
    logic           fcnt_last;
`endif

    always_comb begin
        slot_end  = run && (cnt == CNT_W'(SLOT_CYCLES - 1));
        frame_end = slot_end && (idx == 2'd3);
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        if (run) begin
            if (slot_end) begin
                cnt_nxt = '0;
                idx_nxt = idx + 2'd1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
        // en is the run value that takes effect at this edge, so the
        // registered blank always matches the cnt/run it is shown with.
        blank_nxt = !en || (cnt_nxt < CNT_W'(DEAD_CYCLES));
`ifdef SSD_SCAN_BLINK_EN
        fcnt_last = (fcnt == FCW'(BLINK_FRAMES - 1));
        phase_nxt = phase;
        if (frame_end && fcnt_last) begin
            phase_nxt = ~phase;
        end
        if (phase_nxt && blink_mask[idx_nxt]) begin
            blank_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run        <= 1'b0;
            cnt        <= '0;
            idx        <= 2'd0;
            active     <= 16'h0000;
            pending    <= 16'h0000;
            pend_full  <= 1'b0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
            scan_blank <= 1'b1;
        end else begin
            run        <= en;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            frame_tick <= frame_end;
            scan_blank <= blank_nxt;
            load_ack   <= 1'b0;
            // Commit needs pend_full=1 and accept needs pend_full=0, so a
            // request that coincides with a commit waits one cycle.
            if (frame_end && pend_full) begin
                active    <= pending;
                pend_full <= 1'b0;
            end else if (load_req && !pend_full) begin
                pending   <= data_in;
                pend_full <= 1'b1;
                load_ack  <= 1'b1;
            end
        end
    end

`ifdef SSD_SCAN_BLINK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (frame_end) begin
            fcnt  <= fcnt_last ? '0 : fcnt + 1'b1;
            phase <= phase_nxt;
        end
    end
`endif

    assign ssd_ctl_en = idx;
    assign disp_data  = active;

endmodule

// File: tb/tb_ssd_scan_sched.sv
// tb_ssd_scan_sched: directed self-checking bench for ssd_scan_sched
// with SLOT_CYCLES=8, DEAD_CYCLES=2 and a queue of expected display values.
module tb_ssd_scan_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load_req = 1'b0;
    logic [15:0] data_in = 16'h0000;
`ifdef SSD_SCAN_BLINK_EN
    logic [3:0]  blink_mask = 4'b0000;
`endif
    logic        load_ack;
    logic        pend_full;
    logic [1:0]  ssd_ctl_en;
    logic [15:0] disp_data;
    logic        scan_blank;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    // Reference state: rc counts the edges at which the scan advanced,
    // so slot position is rc%8 and digit is (rc/8)%4.
    int          rc = 0;
    int          ncyc = 0;
    bit          m_run = 1'b0;
    bit          last_ran = 1'b0;
    logic [15:0] exp_disp = 16'h0000;
    logic [15:0] sb[$];
    int          t_tick;
    int          t_ack;
    bit          found;

    ssd_scan_sched #(
        .SLOT_CYCLES(8),
        .DEAD_CYCLES(2),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .load_req(load_req),
        .data_in(data_in),
`ifdef SSD_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .load_ack(load_ack),
        .pend_full(pend_full),
        .ssd_ctl_en(ssd_ctl_en),
        .disp_data(disp_data),
        .scan_blank(scan_blank),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: advance the reference, then compare the scan outputs.
    task automatic tick();
        bit       en_s;
        bit       rst_s;
        bit       exp_tick;
        bit       exp_blank;
        logic [1:0] exp_idx;
        en_s  = en;
        rst_s = rst;
        @(posedge clk);
        #1;
        ncyc++;
        if (rst_s) begin
            rc       = 0;
            m_run    = 1'b0;
            last_ran = 1'b0;
            exp_disp = 16'h0000;
            sb.delete();
        end else begin
            last_ran = m_run;
            if (m_run) rc++;
            m_run = en_s;
        end
        exp_tick  = last_ran && (rc % 32 == 0);
        exp_blank = !m_run || (rc % 8 < 2);
        exp_idx   = 2'((rc / 8) % 4);
        if (exp_tick && sb.size() > 0) exp_disp = sb.pop_front();
        chk("ssd_ctl_en", 16'(ssd_ctl_en), 16'(exp_idx));
        chk("scan_blank", 16'(scan_blank), 16'(exp_blank));
        chk("frame_tick", 16'(frame_tick), 16'(exp_tick));
        chk("disp_data", disp_data, exp_disp);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_ack", 16'(load_ack), 16'h0);
        chk("rst_pend", 16'(pend_full), 16'h0);

        // Free-running scan
        rst = 1'b0;
        en  = 1'b1;
        repeat (12) tick();

        // First load mid-frame
        load_req = 1'b1;
        data_in  = 16'h1234;
        sb.push_back(16'h1234);
        tick();
        chk("ack1", 16'(load_ack), 16'h1);
        chk("pend1", 16'(pend_full), 16'h1);
        load_req = 1'b0;
        tick();
        chk("ack1_pulse", 16'(load_ack), 16'h0);
        chk("disp_hold", disp_data, 16'h0000);

        // Second load while pending is full: held until the commit
        load_req = 1'b1;
        data_in  = 16'h5678;
        sb.push_back(16'h5678);
        t_tick = -1;
        t_ack  = -1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (frame_tick && t_tick < 0) t_tick = ncyc;
            if (load_ack) begin
                t_ack = ncyc;
                break;
            end
        end
        load_req = 1'b0;
        chk("ack2_seen", 16'(t_ack >= 0), 16'h1);
        chk("ack2_delay", 16'(t_ack - t_tick), 16'd1);
        chk("disp_1234", disp_data, 16'h1234);
        chk("pend2", 16'(pend_full), 16'h1);

        // Next frame shows the second value
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frame_tick) begin
                found = 1'b1;
                break;
            end
        end
        chk("tick2_seen", 16'(found), 16'h1);
        chk("disp_5678", disp_data, 16'h5678);
        chk("pend_clr", 16'(pend_full), 16'h0);

        // Freeze at slot 2, cnt 5
        for (int i = 0; i < 64; i++) begin
            if (m_run && rc % 32 == 20) break;
            tick();
        end
        en = 1'b0;
        repeat (20) tick();
        chk("frz_idx", 16'(ssd_ctl_en), 16'd2);
        chk("frz_blank", 16'(scan_blank), 16'h1);
        en = 1'b1;
        found = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ssd_ctl_en == 2'd3) begin
                found = 1'b1;
                chk("resume_len", 16'(i), 16'd4);
                break;
            end
        end
        chk("resume_seen", 16'(found), 16'h1);

        // Reset while a value is pending and idx=3
        load_req = 1'b1;
        data_in  = 16'hABCD;
        sb.push_back(16'hABCD);
        tick();
        load_req = 1'b0;
        chk("ack3", 16'(load_ack), 16'h1);
        chk("pre_rst_idx", 16'(ssd_ctl_en), 16'd3);
        rst = 1'b1;
        tick();
        chk("rst2_ack", 16'(load_ack), 16'h0);
        chk("rst2_pend", 16'(pend_full), 16'h0);
        chk("rst2_disp", disp_data, 16'h0000);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frame_tick) begin
                found = 1'b1;
                break;
            end
        end
        chk("tick3_seen", 16'(found), 16'h1);
        chk("discard_disp", disp_data, 16'h0000);
        chk("discard_pend", 16'(pend_full), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
